// File: rtl/board_vga_render_if.sv
// Game-logic side of the board renderer: cell write/read port, clear sweep
// control and cursor placement. The game logic is the master.
interface board_vga_render_if #(
  parameter int RW  = 3,
  parameter int CLW = 3
);
  logic           wr_en;
  logic [RW-1:0]  wr_row;
  logic [CLW-1:0] wr_col;
  logic [2:0]     wr_color;
  logic [RW-1:0]  rd_row;
  logic [CLW-1:0] rd_col;
  logic [2:0]     rd_color;
  logic           clear_start;
  logic [2:0]     clear_color;
  logic           busy;
  logic           cursor_en;
  logic [RW-1:0]  cursor_row;
  logic [CLW-1:0] cursor_col;

  modport master (
    output wr_en, wr_row, wr_col, wr_color, rd_row, rd_col,
           clear_start, clear_color, cursor_en, cursor_row, cursor_col,
    input  rd_color, busy
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_color, rd_row, rd_col,
           clear_start, clear_color, cursor_en, cursor_row, cursor_col,
    output rd_color, busy
  );
endinterface

// File: rtl/board_vga_render.sv
// Board renderer for vgac: owns the colour-index board, runs the clear sweep and
// cursor blink, and turns the scan position into a pixel with 2 clk latency.
module board_vga_render #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int CELL   = 50,
  parameter int X0     = 120,
  parameter int Y0     = 40,
  parameter int BORDER = 2,
  parameter int BLINK  = 12_500_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  output logic [18:0] cover_addr,
  input  logic [11:0] cover_pix,
  output logic [11:0] vga_data,
  board_vga_render_if.slave bus
);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int LW  = $clog2(CELL);
  localparam int BW  = (BLINK > 1) ? $clog2(BLINK) : 1;

  localparam logic signed [11:0] X0_S   = 12'(X0);
  localparam logic signed [11:0] Y0_S   = 12'(Y0);
  localparam logic signed [11:0] BRD_W  = 12'(COLS * CELL);
  localparam logic signed [11:0] BRD_H  = 12'(ROWS * CELL);
  localparam logic [11:0]        CELL_U = 12'(CELL);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SWEEP = 1'b1;

  function automatic logic [11:0] palette(input logic [2:0] idx);
    case (idx)
      3'd0:    palette = 12'hF00;
      3'd1:    palette = 12'h0F0;
      3'd2:    palette = 12'h00F;
      3'd3:    palette = 12'hFF0;
      3'd4:    palette = 12'hF0F;
      3'd5:    palette = 12'hFFF;
      default: palette = 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] dim_pix(input logic [11:0] p);
    dim_pix = {1'b0, p[11:9], 1'b0, p[7:5], 1'b0, p[3:1]};
  endfunction

  logic [2:0]     board_q [ROWS][COLS];
  logic [2:0]     board_d [ROWS][COLS];
  logic [0:0]     state_q, state_d;
  logic [RW-1:0]  ptr_r_q, ptr_r_d;
  logic [CLW-1:0] ptr_c_q, ptr_c_d;
  logic [2:0]     fill_q, fill_d;
  logic [2:0]     rd_color_q, rd_color_d;
  logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
  logic           blink_phase_q, blink_phase_d;
  logic           wr_ok;

  assign bus.busy     = (state_q == SWEEP);
  assign bus.rd_color = rd_color_q;

  // Board update: sweep owns the array while busy; otherwise the write port does.
  always_comb begin
    board_d = board_q;
    state_d = state_q;
    ptr_r_d = ptr_r_q;
    ptr_c_d = ptr_c_q;
    fill_d  = fill_q;
    wr_ok   = bus.wr_en && (int'(bus.wr_row) < ROWS) && (int'(bus.wr_col) < COLS);
    if (state_q == IDLE) begin
      if (wr_ok) board_d[bus.wr_row][bus.wr_col] = bus.wr_color;
      if (bus.clear_start) begin
        state_d = SWEEP;
        fill_d  = bus.clear_color;
        ptr_r_d = '0;
        ptr_c_d = '0;
      end
    end else begin
      board_d[ptr_r_q][ptr_c_q] = fill_q;
      if (ptr_c_q == CLW'(COLS - 1)) begin
        ptr_c_d = '0;
        if (ptr_r_q == RW'(ROWS - 1)) state_d = IDLE;
        else                          ptr_r_d = ptr_r_q + RW'(1);
      end else begin
        ptr_c_d = ptr_c_q + CLW'(1);
      end
    end
    rd_color_d = ((int'(bus.rd_row) < ROWS) && (int'(bus.rd_col) < COLS)) ?
                 board_d[bus.rd_row][bus.rd_col] : 3'd0;
  end

  always_comb begin
    if (blink_cnt_q == BW'(BLINK - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BW'(1);
      blink_phase_d = blink_phase_q;
    end
  end

  // ---- stage 0: scan position decode ----
  logic signed [11:0] rel_row_p0, rel_col_p0;
  logic               in_board_p0, in_cover_p0;
  logic [RW-1:0]      cr_p0;
  logic [CLW-1:0]     cc_p0;
  logic [LW-1:0]      lr_p0, lc_p0;
  logic [18:0]        cover_addr_p0;
  logic [1:0]         mode_p0;

  always_comb begin
    rel_row_p0    = $signed({3'b000, row_addr}) - Y0_S;
    rel_col_p0    = $signed({2'b00, col_addr}) - X0_S;
    in_board_p0   = (rel_row_p0 >= 12'sd0) && (rel_row_p0 < BRD_H) &&
                    (rel_col_p0 >= 12'sd0) && (rel_col_p0 < BRD_W);
    cr_p0         = RW'($unsigned(rel_row_p0) / CELL_U);
    cc_p0         = CLW'($unsigned(rel_col_p0) / CELL_U);
    lr_p0         = LW'($unsigned(rel_row_p0) % CELL_U);
    lc_p0         = LW'($unsigned(rel_col_p0) % CELL_U);
    in_cover_p0   = (row_addr < 9'd480) && (col_addr < 10'd640);
    cover_addr_p0 = in_cover_p0 ? (19'(row_addr) * 19'd640 + 19'(col_addr)) : 19'd0;
    mode_p0       = (mode == 2'd3) ? 2'd2 : mode;
  end

  // ---- stage 1: registered decode ----
  logic [18:0]    cover_addr_p1;
  logic           in_board_p1, in_cover_p1;
  logic [1:0]     mode_p1;
  logic [RW-1:0]  cr_p1;
  logic [CLW-1:0] cc_p1;
  logic [LW-1:0]  lr_p1, lc_p1;

  assign cover_addr = cover_addr_p1;

  logic [11:0] game_pix_p1, vga_p1;
  logic        edge_hit_p1, cursor_hit_p1, grid_hit_p1;

  always_comb begin
    edge_hit_p1   = (int'(lr_p1) < BORDER) || (int'(lr_p1) >= CELL - BORDER) ||
                    (int'(lc_p1) < BORDER) || (int'(lc_p1) >= CELL - BORDER);
    cursor_hit_p1 = bus.cursor_en && blink_phase_q && (cr_p1 == bus.cursor_row) &&
                    (cc_p1 == bus.cursor_col) && edge_hit_p1;
    grid_hit_p1   = (int'(lr_p1) < BORDER) || (int'(lc_p1) < BORDER);
    if (!in_board_p1)       game_pix_p1 = 12'hFFF;
    else if (cursor_hit_p1) game_pix_p1 = 12'hF80;
    else if (grid_hit_p1)   game_pix_p1 = 12'h888;
    else                    game_pix_p1 = palette(board_q[cr_p1][cc_p1]);
    case (mode_p1)
      2'd0:    vga_p1 = in_cover_p1 ? cover_pix : 12'h000;
      2'd1:    vga_p1 = game_pix_p1;
      default: vga_p1 = dim_pix(game_pix_p1);
    endcase
  end

  // ---- stage 2: registered pixel ----
  logic [11:0] vga_data_p2;
  assign vga_data = vga_data_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          board_q[r][c] <= 3'((r * COLS + c) % 6);
      state_q       <= IDLE;
      ptr_r_q       <= '0;
      ptr_c_q       <= '0;
      rd_color_q    <= 3'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      cover_addr_p1 <= 19'd0;
      in_board_p1   <= 1'b0;
      in_cover_p1   <= 1'b0;
      mode_p1       <= 2'd0;
      vga_data_p2   <= 12'h000;
    end else begin
      board_q       <= board_d;
      state_q       <= state_d;
      ptr_r_q       <= ptr_r_d;
      ptr_c_q       <= ptr_c_d;
      rd_color_q    <= rd_color_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      cover_addr_p1 <= cover_addr_p0;
      in_board_p1   <= in_board_p0;
      in_cover_p1   <= in_cover_p0;
      mode_p1       <= mode_p0;
      vga_data_p2   <= vga_p1;
    end
  end

  always_ff @(posedge clk) begin
    fill_q <= fill_d;
    cr_p1  <= cr_p0;
    cc_p1  <= cc_p0;
    lr_p1  <= lr_p0;
    lc_p1  <= lc_p0;
  end
endmodule
